// File: rtl/ysyx_23060236_div_iter_pkg.sv
// Shared definitions for the iterative divider: FSM state encodings and the
// default operand width.
package ysyx_23060236_div_iter_pkg;

    // Default operand/result width (RV32M); must be even
    localparam int DIV_WIDTH = 32;

    // Divider control states
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } divState_e;

endpackage

// File: rtl/ysyx_23060236_div_step.sv
// One restoring division step: shift {prem,quot} left by one, try to
// subtract the divisor, keep the difference if it did not go negative and
// shift the resulting quotient bit in at the bottom. Purely combinational.
module ysyx_23060236_div_step
    import ysyx_23060236_div_iter_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   prem_i,
    input  logic [WIDTH-1:0] quot_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   prem_o,
    output logic [WIDTH-1:0] quot_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // Trial subtraction one bit wider than prem so its MSB is a clean sign bit
    always_comb begin
        shifted = {prem_i, quot_i[WIDTH-1]};
        trial   = shifted - {2'b00, divisor_i};
        prem_o  = trial[WIDTH+1] ? shifted[WIDTH:0] : trial[WIDTH:0];
        quot_o  = {quot_i[WIDTH-2:0], ~trial[WIDTH+1]};
    end

endmodule

// File: rtl/ysyx_23060236_div_iter.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU. Accepts a request
// on div_valid & div_ready, runs one (or two) restoring steps per cycle and
// pulses div_outvalid for one cycle with the sign-corrected quotient and
// remainder on res/rem.
// Optional build macro: YSYX_23060236_DIV_RADIX4_EN retires two quotient
// bits per cycle by cascading two step instances.
module ysyx_23060236_div_iter
    import ysyx_23060236_div_iter_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             div_valid,
    output logic             div_ready,
    input  logic             div_sign,
    input  logic [WIDTH-1:0] div1,
    input  logic [WIDTH-1:0] div2,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] rem,
    output logic             div_outvalid
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};

    divState_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   prem_q, prem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic             qNeg_q, qNeg_d;
    logic             rNeg_q, rNeg_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    logic [WIDTH:0]   stepPrem;
    logic [WIDTH-1:0] stepQuot;
    logic [WIDTH-1:0] absDividend;
    logic [WIDTH-1:0] absDivisor;
    logic             lastStep;

`ifdef YSYX_23060236_DIV_RADIX4_EN
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH / 2 - 1);

    logic [WIDTH:0]   midPrem;
    logic [WIDTH-1:0] midQuot;

    ysyx_23060236_div_step #(.WIDTH(WIDTH)) u_step0 (
        .prem_i    (prem_q),
        .quot_i    (quot_q),
        .divisor_i (divisor_q),
        .prem_o    (midPrem),
        .quot_o    (midQuot)
    );

    ysyx_23060236_div_step #(.WIDTH(WIDTH)) u_step1 (
        .prem_i    (midPrem),
        .quot_i    (midQuot),
        .divisor_i (divisor_q),
        .prem_o    (stepPrem),
        .quot_o    (stepQuot)
    );
`else
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    ysyx_23060236_div_step #(.WIDTH(WIDTH)) u_step0 (
        .prem_i    (prem_q),
        .quot_i    (quot_q),
        .divisor_i (divisor_q),
        .prem_o    (stepPrem),
        .quot_o    (stepQuot)
    );
`endif

    // Operand magnitudes; abs(MIN_INT) wraps to itself, which is exact as unsigned
    always_comb begin
        absDividend = (div_sign && div1[WIDTH-1]) ? -div1 : div1;
        absDivisor  = (div_sign && div2[WIDTH-1]) ? -div2 : div2;
        lastStep    = (cnt_q == LAST_CNT);
    end

    // Next-state logic: accept, iterate, then sign-correct into res/rem on exit
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prem_d    = prem_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
        qNeg_d    = qNeg_q;
        rNeg_d    = rNeg_q;
        res_d     = res_q;
        rem_d     = rem_q;
        case (state_q)
            DIV_IDLE: begin
                if (div_valid) begin
                    if (div2 == '0) begin
                        res_d   = ALL_ONES;
                        rem_d   = div1;
                        state_d = DIV_DONE;
                    end else if (div_sign && (div1 == MIN_INT) && (div2 == ALL_ONES)) begin
                        res_d   = MIN_INT;
                        rem_d   = '0;
                        state_d = DIV_DONE;
                    end else begin
                        prem_d    = '0;
                        quot_d    = absDividend;
                        divisor_d = absDivisor;
                        qNeg_d    = div_sign & (div1[WIDTH-1] ^ div2[WIDTH-1]);
                        rNeg_d    = div_sign & div1[WIDTH-1];
                        cnt_d     = '0;
                        state_d   = DIV_CALC;
                    end
                end
            end
            DIV_CALC: begin
                prem_d = stepPrem;
                quot_d = stepQuot;
                cnt_d  = cnt_q + CNT_W'(1);
                if (lastStep) begin
                    res_d   = qNeg_q ? -stepQuot : stepQuot;
                    rem_d   = rNeg_q ? -stepPrem[WIDTH-1:0] : stepPrem[WIDTH-1:0];
                    state_d = DIV_IDLE;
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    // State register; reset aborts any division and clears the results
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            prem_q    <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
            qNeg_q    <= 1'b0;
            rNeg_q    <= 1'b0;
            res_q     <= '0;
            rem_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prem_q    <= prem_d;
            quot_q    <= quot_d;
            divisor_q <= divisor_d;
            qNeg_q    <= qNeg_d;
            rNeg_q    <= rNeg_d;
            res_q     <= res_d;
            rem_q     <= rem_d;
        end
    end

    // Handshake and result outputs decode directly from registered state
    always_comb begin
        div_ready    = (state_q == DIV_IDLE);
        div_outvalid = (state_q == DIV_DONE);
        res          = res_q;
        rem          = rem_q;
    end

endmodule
